// File: rtl/conv_window_line_buffer.sv
// conv_window_line_buffer: streaming 5x5 window generator over a raster pixel stream
module conv_window_line_buffer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] pixel_in,
    output logic signed [DATA_W-1:0] data_out_0,
    output logic signed [DATA_W-1:0] data_out_1,
    output logic signed [DATA_W-1:0] data_out_2,
    output logic signed [DATA_W-1:0] data_out_3,
    output logic signed [DATA_W-1:0] data_out_4,
    output logic signed [DATA_W-1:0] data_out_5,
    output logic signed [DATA_W-1:0] data_out_6,
    output logic signed [DATA_W-1:0] data_out_7,
    output logic signed [DATA_W-1:0] data_out_8,
    output logic signed [DATA_W-1:0] data_out_9,
    output logic signed [DATA_W-1:0] data_out_10,
    output logic signed [DATA_W-1:0] data_out_11,
    output logic signed [DATA_W-1:0] data_out_12,
    output logic signed [DATA_W-1:0] data_out_13,
    output logic signed [DATA_W-1:0] data_out_14,
    output logic signed [DATA_W-1:0] data_out_15,
    output logic signed [DATA_W-1:0] data_out_16,
    output logic signed [DATA_W-1:0] data_out_17,
    output logic signed [DATA_W-1:0] data_out_18,
    output logic signed [DATA_W-1:0] data_out_19,
    output logic signed [DATA_W-1:0] data_out_20,
    output logic signed [DATA_W-1:0] data_out_21,
    output logic signed [DATA_W-1:0] data_out_22,
    output logic signed [DATA_W-1:0] data_out_23,
    output logic signed [DATA_W-1:0] data_out_24,
    output logic                     valid_out_buf,
    output logic                     frame_done
);
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int TAPS = K * K;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_EDGE = CW'(K - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(K - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic signed [DATA_W-1:0] rb0 [IMG_W];
    logic signed [DATA_W-1:0] rb1 [IMG_W];
    logic signed [DATA_W-1:0] rb2 [IMG_W];
    logic signed [DATA_W-1:0] rb3 [IMG_W];
    logic signed [DATA_W-1:0] win [TAPS];
    logic signed [DATA_W-1:0] new_col [K];

    // incoming window column, oldest row on top, built from pre-write buffer contents
    always_comb begin
        new_col[0] = rb3[col];
        new_col[1] = rb2[col];
        new_col[2] = rb1[col];
        new_col[3] = rb0[col];
        new_col[4] = pixel_in;
    end

    // row buffers age one row per accepted pixel at the current column; contents need no reset
    always_ff @(posedge clk) begin
        if (valid_in) begin
            rb0[col] <= pixel_in;
            rb1[col] <= rb0[col];
            rb2[col] <= rb1[col];
            rb3[col] <= rb2[col];
        end
    end

    // window shifts left and takes the new column on the right for every accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) win[i] <= '0;
        end else if (valid_in) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) win[i*K+j] <= win[i*K+j+1];
                win[i*K+K-1] <= new_col[i];
            end
        end
    end

    // raster position tracking and strobes; a window is valid only once it lies fully inside the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            valid_out_buf <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            valid_out_buf <= valid_in && row >= ROW_EDGE && col >= COL_EDGE;
            frame_done    <= valid_in && row == ROW_LAST && col == COL_LAST;
            if (valid_in) begin
                col <= (col == COL_LAST) ? '0 : col + 1'b1;
                if (col == COL_LAST) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end
        end
    end

    assign data_out_0  = win[0];
    assign data_out_1  = win[1];
    assign data_out_2  = win[2];
    assign data_out_3  = win[3];
    assign data_out_4  = win[4];
    assign data_out_5  = win[5];
    assign data_out_6  = win[6];
    assign data_out_7  = win[7];
    assign data_out_8  = win[8];
    assign data_out_9  = win[9];
    assign data_out_10 = win[10];
    assign data_out_11 = win[11];
    assign data_out_12 = win[12];
    assign data_out_13 = win[13];
    assign data_out_14 = win[14];
    assign data_out_15 = win[15];
    assign data_out_16 = win[16];
    assign data_out_17 = win[17];
    assign data_out_18 = win[18];
    assign data_out_19 = win[19];
    assign data_out_20 = win[20];
    assign data_out_21 = win[21];
    assign data_out_22 = win[22];
    assign data_out_23 = win[23];
    assign data_out_24 = win[24];
endmodule

// File: tb/tb_conv_window_line_buffer.sv
// tb_conv_window_line_buffer: directed scenario bench for the 5x5 window line buffer
module tb_conv_window_line_buffer;
    logic clk;
    logic rst;
    logic valid_in;
    logic signed [7:0] pixel_in;
    logic signed [7:0] d [25];
    logic valid_out_buf;
    logic frame_done;
    int total;
    int bad;
    int strobes;
    int fds;
    logic signed [7:0] first_d0 [2];
    logic signed [7:0] first_d24 [2];
    logic signed [7:0] first_d4;
    logic signed [7:0] first_d5;
    logic signed [7:0] last_d24;

    conv_window_line_buffer dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pixel_in(pixel_in),
        .data_out_0(d[0]), .data_out_1(d[1]), .data_out_2(d[2]), .data_out_3(d[3]), .data_out_4(d[4]),
        .data_out_5(d[5]), .data_out_6(d[6]), .data_out_7(d[7]), .data_out_8(d[8]), .data_out_9(d[9]),
        .data_out_10(d[10]), .data_out_11(d[11]), .data_out_12(d[12]), .data_out_13(d[13]), .data_out_14(d[14]),
        .data_out_15(d[15]), .data_out_16(d[16]), .data_out_17(d[17]), .data_out_18(d[18]), .data_out_19(d[19]),
        .data_out_20(d[20]), .data_out_21(d[21]), .data_out_22(d[22]), .data_out_23(d[23]), .data_out_24(d[24]),
        .valid_out_buf(valid_out_buf), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: ramp (28r+c) mod 128; mode 1: -128 + ((28r+c) mod 256); frame f shifts the ramp by 64
    function automatic logic signed [7:0] pix(input int mode, input int f, input int r, input int c);
        int l;
        l = 28 * r + c + 64 * f;
        return (mode == 0) ? 8'(l % 128) : 8'((l % 256) - 128);
    endfunction

    // drive one cycle from a falling edge; outputs for this input are visible on return
    task automatic step(input logic v, input logic signed [7:0] p);
        valid_in = v;
        pixel_in = p;
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_frames(input int mode, input int max_gap, input int nfr);
        logic signed [7:0] e;
        bit v, fd, last_v;
        int last_r, last_c, last_f, g;
        strobes = 0;
        fds = 0;
        last_v = 0;
        last_r = 0;
        last_c = 0;
        last_f = 0;
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < 28; r++) begin
                for (int c = 0; c < 28; c++) begin
                    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                    repeat (g) begin
                        step(1'b0, 8'($urandom));
                        total++;
                        if (valid_out_buf !== 1'b0 || frame_done !== 1'b0) begin
                            bad++;
                            $display("FAIL gap_strobe f=%0d r=%0d c=%0d valid=%b done=%b want 0 0", f, r, c, valid_out_buf, frame_done);
                        end
                        if (last_v) begin
                            total++;
                            e = pix(mode, last_f, last_r, last_c);
                            if (d[24] !== e || d[0] !== pix(mode, last_f, last_r - 4, last_c - 4)) begin
                                bad++;
                                $display("FAIL gap_hold f=%0d r=%0d c=%0d d24=%0d want %0d", f, r, c, d[24], e);
                            end
                        end
                    end
                    step(1'b1, pix(mode, f, r, c));
                    v = (r >= 4 && c >= 4);
                    fd = (r == 27 && c == 27);
                    total++;
                    if (valid_out_buf !== v) begin
                        bad++;
                        $display("FAIL valid f=%0d r=%0d c=%0d got %b want %b", f, r, c, valid_out_buf, v);
                    end
                    total++;
                    if (frame_done !== fd) begin
                        bad++;
                        $display("FAIL frame_done f=%0d r=%0d c=%0d got %b want %b", f, r, c, frame_done, fd);
                    end
                    if (valid_out_buf === 1'b1) strobes++;
                    if (frame_done === 1'b1) fds++;
                    if (v) begin
                        for (int k = 0; k < 25; k++) begin
                            total++;
                            e = pix(mode, f, r - 4 + k / 5, c - 4 + k % 5);
                            if (d[k] !== e) begin
                                bad++;
                                $display("FAIL tap f=%0d r=%0d c=%0d k=%0d got %0d want %0d", f, r, c, k, d[k], e);
                            end
                        end
                    end
                    if (r == 4 && c == 4) begin
                        first_d0[f] = d[0];
                        first_d24[f] = d[24];
                        first_d4 = d[4];
                        first_d5 = d[5];
                    end
                    if (fd) last_d24 = d[24];
                    last_v = v;
                    last_r = r;
                    last_c = c;
                    last_f = f;
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        pixel_in = 8'sd0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            total++;
            if (d[k] !== 8'sd0) begin
                bad++;
                $display("FAIL reset_tap k=%0d got %0d want 0", k, d[k]);
            end
        end
        total++;
        if (valid_out_buf !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags valid=%b done=%b want 0 0", valid_out_buf, frame_done);
        end
        rst = 1'b0;
        step(1'b0, 8'sd55);
        total++;
        if (valid_out_buf !== 1'b0 || d[24] !== 8'sd0) begin
            bad++;
            $display("FAIL idle_after_reset valid=%b d24=%0d want 0 0", valid_out_buf, d[24]);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        test_frames(0, 0, 1);
        total++;
        if (strobes !== 576) begin bad++; $display("FAIL ramp_strobes got %0d want 576", strobes); end
        total++;
        if (fds !== 1) begin bad++; $display("FAIL ramp_frame_done got %0d want 1", fds); end
        total++;
        if (first_d0[0] !== 8'sd0 || first_d4 !== 8'sd4 || first_d5 !== 8'sd28 || first_d24[0] !== 8'sd116) begin
            bad++;
            $display("FAIL ramp_first_window got %0d %0d %0d %0d want 0 4 28 116", first_d0[0], first_d4, first_d5, first_d24[0]);
        end
        total++;
        if (last_d24 !== 8'sd15) begin bad++; $display("FAIL ramp_last_window got %0d want 15", last_d24); end
    endtask

    task automatic test_gaps();
        do_reset();
        test_frames(0, 3, 1);
        total++;
        if (strobes !== 576 || fds !== 1) begin
            bad++;
            $display("FAIL gaps_counts strobes=%0d done=%0d want 576 1", strobes, fds);
        end
        total++;
        if (first_d24[0] !== 8'sd116 || last_d24 !== 8'sd15) begin
            bad++;
            $display("FAIL gaps_windows first=%0d last=%0d want 116 15", first_d24[0], last_d24);
        end
    endtask

    task automatic test_edge_mask();
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 28; c++) begin
                if (r == 5 && c == 5) break;
                step(1'b1, pix(0, 0, r, c));
                if (r >= 4 && c < 4) begin
                    total++;
                    if (valid_out_buf !== 1'b0) begin
                        bad++;
                        $display("FAIL edge_mask r=%0d c=%0d got %b want 0", r, c, valid_out_buf);
                    end
                end
                if (r == 5 && c == 4) begin
                    total++;
                    if (valid_out_buf !== 1'b1 || d[0] !== 8'sd28) begin
                        bad++;
                        $display("FAIL edge_first r=5 c=4 valid=%b d0=%0d want 1 28", valid_out_buf, d[0]);
                    end
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_negative();
        do_reset();
        test_frames(1, 0, 1);
        total++;
        if (first_d0[0] !== 8'sh80) begin bad++; $display("FAIL neg_d0 got %h want 80", first_d0[0]); end
        total++;
        if (first_d24[0] !== -8'sd12) begin bad++; $display("FAIL neg_d24 got %0d want -12", first_d24[0]); end
        total++;
        if (strobes !== 576) begin bad++; $display("FAIL neg_strobes got %0d want 576", strobes); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        test_frames(0, 0, 2);
        total++;
        if (strobes !== 1152 || fds !== 2) begin
            bad++;
            $display("FAIL b2b_counts strobes=%0d done=%0d want 1152 2", strobes, fds);
        end
        total++;
        if (first_d0[1] !== 8'sd64 || first_d24[1] !== 8'sd52) begin
            bad++;
            $display("FAIL b2b_second_first d0=%0d d24=%0d want 64 52", first_d0[1], first_d24[1]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10 * 28 + 7; i++) step(1'b1, pix(0, 0, i / 28, i % 28));
        total++;
        if (valid_out_buf !== 1'b1 || d[24] !== 8'sd30) begin
            bad++;
            $display("FAIL pre_reset valid=%b d24=%0d want 1 30", valid_out_buf, d[24]);
        end
        valid_in = 1'b1;
        pixel_in = pix(0, 0, 10, 7);
        #2 rst = 1'b1;
        #1;
        total++;
        if (valid_out_buf !== 1'b0 || frame_done !== 1'b0 || d[24] !== 8'sd0 || d[0] !== 8'sd0) begin
            bad++;
            $display("FAIL async_reset valid=%b done=%b d0=%0d d24=%0d want 0 0 0 0", valid_out_buf, frame_done, d[0], d[24]);
        end
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        test_frames(0, 0, 1);
        total++;
        if (strobes !== 576 || fds !== 1 || first_d24[0] !== 8'sd116 || last_d24 !== 8'sd15) begin
            bad++;
            $display("FAIL post_reset_frame strobes=%0d done=%0d first=%0d last=%0d want 576 1 116 15", strobes, fds, first_d24[0], last_d24);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_ramp();
        test_gaps();
        test_edge_mask();
        test_negative();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
